// File: rtl/ep2_packet_demux_if.sv
// ep2_packet_demux_if: EP2 byte stream in, broadcast byte plus one-hot FIFO write strobes out
interface ep2_packet_demux_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [3:0] out_writes;
  logic [3:0] out_fulls;
  modport master (output in_data, in_valid, out_fulls, input in_ready, out_data, out_writes);
  modport slave (input in_data, in_valid, out_fulls, output in_ready, out_data, out_writes);
endinterface

// File: rtl/ep2_packet_demux.sv
// ep2_packet_demux: steers framed EP2 packets (port header, 16-bit length, payload) into four write FIFOs; optional DEMUX_ERRCOUNT_EN adds a saturating malformed-header counter
module ep2_packet_demux #(
  parameter int NUM_PORTS   = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  ep2_packet_demux_if.slave                bus,
  output logic [NUM_PORTS*COUNT_WIDTH-1:0] write_fifo_byte_counts
`ifdef DEMUX_ERRCOUNT_EN
  ,
  output logic [7:0]                       error_count
`endif
);
  typedef enum logic [2:0] {HDR_PORT, HDR_LEN_HI, HDR_LEN_LO, PAYLOAD, DISCARD} state_t;
  state_t state, state_nx;
  logic [1:0] port;
  logic invalid;
  logic [7:0] len_hi;
  logic [15:0] remaining;
  logic [NUM_PORTS-1:0][COUNT_WIDTH-1:0] counts;
  logic xfer, last;
  assign bus.in_ready = (state == PAYLOAD) ? !bus.out_fulls[port] : 1'b1;
  assign xfer = bus.in_valid && bus.in_ready;
  assign last = remaining == 16'd1;
  assign bus.out_data = bus.in_data;
  assign bus.out_writes = (state == PAYLOAD && xfer) ? 4'b0001 << port : 4'b0000;
  assign write_fifo_byte_counts = counts;
  // next-state: headers advance one byte per transfer; body states exit on the final byte
  always_comb begin
    state_nx = state;
    if (xfer)
      case (state)
        HDR_PORT:          state_nx = HDR_LEN_HI;
        HDR_LEN_HI:        state_nx = HDR_LEN_LO;
        HDR_LEN_LO:        state_nx = ({len_hi, bus.in_data} == 16'd0) ? HDR_PORT : invalid ? DISCARD : PAYLOAD;
        PAYLOAD, DISCARD:  state_nx = last ? HDR_PORT : state;
        default:           state_nx = HDR_PORT;
      endcase
  end
  // state register; reset abandons any packet in flight
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= HDR_PORT;
    else state <= state_nx;
  // header fields and remaining body length
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      port      <= '0;
      invalid   <= 1'b0;
      len_hi    <= '0;
      remaining <= '0;
    end else if (xfer) begin
      if (state == HDR_PORT) begin
        port    <= bus.in_data[1:0];
        invalid <= |bus.in_data[7:2];
      end
      if (state == HDR_LEN_HI) len_hi <= bus.in_data;
      if (state == HDR_LEN_LO) remaining <= {len_hi, bus.in_data};
      if (state == PAYLOAD || state == DISCARD) remaining <= remaining - 16'd1;
    end
  // per-port byte counters, free-running and wrapping
  always_ff @(posedge clk or negedge reset)
    if (!reset) counts <= '0;
    else
      for (int i = 0; i < NUM_PORTS; i++)
        if (bus.out_writes[i]) counts[i] <= counts[i] + 1'b1;
`ifdef DEMUX_ERRCOUNT_EN
  // saturating count of headers with nonzero reserved bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) error_count <= '0;
    else if (state == HDR_PORT && xfer && |bus.in_data[7:2] && error_count != 8'hFF) error_count <= error_count + 8'd1;
`endif
endmodule
